// File: rtl/prog_loader.sv
// prog_loader: UART (8N1) boot loader. Receives a little-endian 32-bit word
// count followed by that many little-endian 32-bit words and writes them to
// consecutive memory words, holding the core in reset until the image is in.
module prog_loader #(
    parameter int CLK_PER_BIT = 100,
    parameter int ENTRY       = 256,
    localparam int AW         = (ENTRY > 1) ? $clog2(ENTRY) : 1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          RXD,
    output logic [3:0]    MEM_WE,
    output logic [AW-1:0] MEM_ADDR,
    output logic [31:0]   MEM_WDATA,
    output logic          CORE_RST,
    output logic          DONE,
    output logic          ERR
);

    localparam logic [15:0] HALF_M1 = 16'(CLK_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL_M1 = 16'(CLK_PER_BIT - 1);

    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAIT} rx_state_t;
    typedef enum logic [1:0] {L_HDR, L_DATA, L_WRITE, L_DONE} ld_state_t;

    rx_state_t   rx_state, rx_state_nxt;
    ld_state_t   ld_state, ld_state_nxt;

    logic        rx_s1, rx_s2, rx_d;
    logic [15:0] bit_tmr;
    logic [2:0]  bit_idx;
    logic [7:0]  rx_shift;
    logic        tmr_zero, rx_fall, byte_vld, frame_err;

    logic [1:0]  byte_cnt;
    logic [31:0] word_asm, word_nxt, n_words, word_idx;
    logic        in_range;

    assign tmr_zero  = (bit_tmr == 16'd0);
    assign rx_fall   = rx_d & ~rx_s2;
    assign word_nxt  = {rx_shift, word_asm[31:8]};
    assign in_range  = (word_idx < 32'(ENTRY));
    assign MEM_ADDR  = word_idx[AW-1:0];
    assign MEM_WDATA = word_asm;

    // RXD synchronizer plus one delayed copy for falling-edge detection
    always_ff @(posedge CLK) begin
        if (RST) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_d  <= 1'b1;
        end else begin
            rx_s1 <= RXD;
            rx_s2 <= rx_s1;
            rx_d  <= rx_s2;
        end
    end

    // Receiver and loader state registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            rx_state <= R_IDLE;
            ld_state <= L_HDR;
        end else begin
            rx_state <= rx_state_nxt;
            ld_state <= ld_state_nxt;
        end
    end

    // Receiver next state; byte_vld fires in the cycle a good stop bit is sampled
    always_comb begin
        rx_state_nxt = rx_state;
        byte_vld     = 1'b0;
        frame_err    = 1'b0;
        case (rx_state)
            R_IDLE:  if (rx_fall) rx_state_nxt = R_START;
            R_START: if (tmr_zero) rx_state_nxt = rx_s2 ? R_IDLE : R_DATA;
            R_DATA:  if (tmr_zero && bit_idx == 3'd7) rx_state_nxt = R_STOP;
            R_STOP: begin
                if (tmr_zero) begin
                    if (rx_s2) begin
                        byte_vld     = 1'b1;
                        rx_state_nxt = R_IDLE;
                    end else begin
                        frame_err    = 1'b1;
                        rx_state_nxt = R_WAIT;
                    end
                end
            end
            // after a framing error, re-arm only once the line is back high
            R_WAIT:  if (rx_s2) rx_state_nxt = R_IDLE;
            default: rx_state_nxt = R_IDLE;
        endcase
    end

    // Bit timer and LSB-first shift register; idle preloads the half-bit delay
    always_ff @(posedge CLK) begin
        if (RST) begin
            bit_tmr  <= HALF_M1;
            bit_idx  <= 3'd0;
            rx_shift <= 8'd0;
        end else begin
            case (rx_state)
                R_IDLE, R_WAIT: begin
                    bit_tmr <= HALF_M1;
                    bit_idx <= 3'd0;
                end
                R_START, R_STOP: bit_tmr <= tmr_zero ? FULL_M1 : bit_tmr - 16'd1;
                R_DATA: begin
                    if (tmr_zero) begin
                        rx_shift <= {rx_s2, rx_shift[7:1]};
                        bit_idx  <= bit_idx + 3'd1;
                        bit_tmr  <= FULL_M1;
                    end else begin
                        bit_tmr  <= bit_tmr - 16'd1;
                    end
                end
                default: bit_tmr <= HALF_M1;
            endcase
        end
    end

    // Loader next state and memory/core outputs
    always_comb begin
        ld_state_nxt = ld_state;
        MEM_WE       = 4'h0;
        CORE_RST     = 1'b1;
        DONE         = 1'b0;
        case (ld_state)
            L_HDR:
                if (byte_vld && byte_cnt == 2'd3)
                    ld_state_nxt = (word_nxt == 32'd0) ? L_DONE : L_DATA;
            L_DATA:
                if (byte_vld && byte_cnt == 2'd3) ld_state_nxt = L_WRITE;
            L_WRITE: begin
                // out-of-range words are counted but never written (no wrap)
                MEM_WE       = in_range ? 4'hF : 4'h0;
                ld_state_nxt = (word_idx + 32'd1 == n_words) ? L_DONE : L_DATA;
            end
            L_DONE: begin
                CORE_RST = 1'b0;
                DONE     = 1'b1;
            end
            default: ld_state_nxt = L_HDR;
        endcase
    end

    // Byte assembly, word count capture and word index; bytes are accepted in
    // WRITE as well so nothing arriving there is lost
    always_ff @(posedge CLK) begin
        if (RST) begin
            byte_cnt <= 2'd0;
            word_asm <= 32'd0;
            n_words  <= 32'd0;
            word_idx <= 32'd0;
        end else begin
            if (byte_vld && ld_state != L_DONE) begin
                word_asm <= word_nxt;
                byte_cnt <= byte_cnt + 2'd1;
            end
            if (ld_state == L_HDR && byte_vld && byte_cnt == 2'd3)
                n_words <= word_nxt;
            if (ld_state == L_WRITE)
                word_idx <= word_idx + 32'd1;
        end
    end

    // Sticky error: framing error or a word beyond the memory
    always_ff @(posedge CLK) begin
        if (RST)
            ERR <= 1'b0;
        else if (frame_err || (ld_state == L_WRITE && !in_range))
            ERR <= 1'b1;
    end

endmodule
